mem_bus_ctrl: RTL and testbench

//  Sequencer between the CPU core and the unified 16-bit main memory.

---
 rtl/mem_bus_ctrl_if.sv | 31 +++
 rtl/mem_bus_ctrl.sv | 82 ++++++++
 tb/tb_mem_bus_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Core-side request/response and memory control lines of the memory sequencer.
// Master = CPU core side, slave = the mem_bus_ctrl sequencer.
interface mem_bus_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_address;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read_write;
   logic              mem_enable;
   logic              mem_reset_n;

   modport master (
      output req_valid, req_write, req_address, req_wdata,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata,
      input  mem_address, mem_read_write, mem_enable, mem_reset_n
   );

   modport slave (
      input  req_valid, req_write, req_address, req_wdata,
      output req_ready, rsp_valid, rsp_write, rsp_rdata,
      output mem_address, mem_read_write, mem_enable, mem_reset_n
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// One-at-a-time read/write sequencer for the 16-bit main memory; read done 3 cycles, write 2 after accept.
// Backpressure: req_ready only in IDLE, so a new request is taken no earlier than the done-pulse cycle.
module mem_bus_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   mem_bus_ctrl_if.slave     bus,
   inout  wire  [DATA_W-1:0] mem_data
);
   typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_address;
               wdata_d = bus.req_wdata;
               state_d = bus.req_write ? WR : RD_ADDR;
            end
         end
         RD_ADDR: state_d = RD_DATA;
         // Memory presents its mdr during this cycle; capture it on the way out.
         RD_DATA: begin
            rdata_d     = mem_data;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b0;
            state_d     = IDLE;
         end
         WR: begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready      = (state_q == IDLE);
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_write      = rsp_write_q;
   assign bus.rsp_rdata      = rdata_q;
   assign bus.mem_address    = addr_q;
   assign bus.mem_enable     = (state_q != IDLE);
   assign bus.mem_read_write = (state_q != WR);
   assign bus.mem_reset_n    = ~reset;

   // Only WR drives the bus; the memory drives only while read_write is high.
   assign mem_data = (state_q == WR) ? wdata_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: behavioural memory device, transaction-level model with per-cycle compare,
// and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_bus_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus();
   wire [15:0] mem_data;

   mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .mem_data (mem_data)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rsp_cnt = 0;
   int en_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         rsp_cnt += int'(bus.rsp_valid);
         en_cnt  += int'(bus.mem_enable);
      end
   end

   // Memory device: mdr loads while enabled for read, drives the bus from mdr, writes when read_write is low.
   logic [15:0] dev_arr [logic [15:0]];
   logic [15:0] mdr = 16'h0;
   assign mem_data = (bus.mem_enable && bus.mem_read_write) ? mdr : 16'hzzzz;

   always @(posedge clk) begin
      if (!bus.mem_reset_n) begin
         dev_arr.delete();
         mdr <= 16'h0;
      end else if (bus.mem_enable) begin
         if (bus.mem_read_write)
            mdr <= dev_arr.exists(bus.mem_address) ? dev_arr[bus.mem_address] : 16'h0;
         else
            dev_arr[bus.mem_address] = mem_data;
      end
   end

   // Transaction model: an accepted op occupies the memory for 1 (write) or 2 (read) cycles,
   // then reports completion for one cycle while already able to take the next request.
   bit          m_busy = 1'b0;
   bit          m_wr = 1'b0;
   bit          m_rsp = 1'b0;
   bit          m_rsp_wr = 1'b0;
   int          m_age = 0;
   logic [15:0] m_addr = 16'h0;
   logic [15:0] m_data = 16'h0;
   logic [15:0] m_rdata = 16'h0;
   logic [15:0] m_arr [logic [15:0]];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0;
         m_rsp = 1'b0;
         m_rsp_wr = 1'b0;
         m_rdata = 16'h0;
         m_age = 0;
         m_arr.delete();
      end else begin
         m_rsp = 1'b0;
         if (m_busy) begin
            m_age++;
            if (m_wr && m_age == 2) begin
               m_arr[m_addr] = m_data;
               m_busy = 1'b0;
               m_rsp = 1'b1;
               m_rsp_wr = 1'b1;
            end else if (!m_wr && m_age == 3) begin
               m_rdata = m_arr.exists(m_addr) ? m_arr[m_addr] : 16'h0;
               m_busy = 1'b0;
               m_rsp = 1'b1;
               m_rsp_wr = 1'b0;
            end
         end else if (bus.req_valid) begin
            m_busy = 1'b1;
            m_age = 1;
            m_wr = bus.req_write;
            m_addr = bus.req_address;
            m_data = bus.req_wdata;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("req_ready", 32'(!m_busy), 32'(bus.req_ready));
         chk("mem_enable", 32'(bus.mem_enable), 32'(m_busy));
         chk("mem_read_write", 32'(bus.mem_read_write), 32'(!(m_busy && m_wr)));
         if (m_busy) chk("mem_address", 32'(bus.mem_address), 32'(m_addr));
         if (m_busy && m_wr) chk("mem_data_wr", 32'(mem_data), 32'(m_data));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
         if (m_rsp) chk("rsp_write", 32'(bus.rsp_write), 32'(m_rsp_wr));
         chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
         chk("mem_reset_n", 32'(bus.mem_reset_n), 32'd1);
      end
   end

   // Call at a negedge; returns at the negedge right after the accept edge.
   task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input bit hold, output int acc);
      acc = -1;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_address = a;
      bus.req_wdata = d;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready) begin
            acc = cyc;
            @(negedge clk);
            if (!hold) bus.req_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready never seen for addr %h", a);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int at);
      at = -1;
      for (int i = 0; i < 20; i++) begin
         if (bus.rsp_valid) begin
            at = cyc;
            return;
         end
         @(negedge clk);
      end
      tests++;
      fails++;
      $display("FAIL rsp_timeout: no rsp_valid within 20 cycles");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, at;
      logic [4:0] pat;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_address = 16'h0;
      bus.req_wdata = 16'h0;

      // 1: reset values, then reads of never-written words return 0
      #12;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_enable", 32'(bus.mem_enable), 32'd0);
      chk("rst_read_write", 32'(bus.mem_read_write), 32'd1);
      chk("rst_address", 32'(bus.mem_address), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_write", 32'(bus.rsp_write), 32'd0);
      chk("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
      chk("rst_mem_reset_n", 32'(bus.mem_reset_n), 32'd0);
      @(negedge clk); #2 reset = 1'b0;
      @(negedge clk);
      issue(1'b0, 16'h1234, 16'h0, 1'b0, acc);
      wait_rsp(at);
      chk("fresh_read", 32'(bus.rsp_rdata), 32'h0);

      // 2: write then read 0x0042
      idle(2);
      issue(1'b1, 16'h0042, 16'hBEEF, 1'b0, acc);
      wait_rsp(at);
      chk("wr_latency", 32'(at - acc), 32'd2);
      chk("wr_rsp_write", 32'(bus.rsp_write), 32'd1);
      issue(1'b0, 16'h0042, 16'h0, 1'b0, acc);
      wait_rsp(at);
      chk("rd_latency", 32'(at - acc), 32'd3);
      chk("rd_data_beef", 32'(bus.rsp_rdata), 32'hBEEF);
      chk("rd_rsp_write", 32'(bus.rsp_write), 32'd0);

      // 3: req_valid held high across a write then a read at the top address
      idle(2);
      rsp_cnt = 0;
      en_cnt = 0;
      issue(1'b1, 16'hFFFF, 16'h1234, 1'b1, acc);
      bus.req_write = 1'b0;
      bus.req_wdata = 16'h0;
      issue(1'b0, 16'hFFFF, 16'h0, 1'b0, acc);
      wait_rsp(at);
      chk("held_rdata", 32'(bus.rsp_rdata), 32'h1234);
      idle(3);
      chk("held_rsp_pulses", 32'(rsp_cnt), 32'd2);
      chk("held_mem_cycles", 32'(en_cnt), 32'd3);

      // 4: read 0x0000 then write 0x0000 back to back; enable must drop between them
      issue(1'b0, 16'h0000, 16'h0, 1'b1, acc);
      bus.req_write = 1'b1;
      bus.req_wdata = 16'hA5A5;
      for (int k = 0; k < 5; k++) begin
         pat[k] = bus.mem_enable;
         if (k == 2) chk("b2b_read_zero", 32'(bus.rsp_rdata), 32'h0);
         if (k == 3) bus.req_valid = 1'b0;
         @(negedge clk);
      end
      chk("b2b_enable_pattern", 32'(pat), 32'b01011);
      issue(1'b0, 16'h0000, 16'h0, 1'b0, acc);
      wait_rsp(at);
      chk("b2b_readback", 32'(bus.rsp_rdata), 32'hA5A5);

      // 5: reset during RD_DATA
      idle(2);
      rsp_cnt = 0;
      issue(1'b0, 16'h0042, 16'h0, 1'b0, acc);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_enable", 32'(bus.mem_enable), 32'd0);
      chk("mid_rst_read_write", 32'(bus.mem_read_write), 32'd1);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_rdata", 32'(bus.rsp_rdata), 32'h0);
      chk("mid_rst_address", 32'(bus.mem_address), 32'h0);
      chk("mid_rst_mem_reset_n", 32'(bus.mem_reset_n), 32'd0);
      idle(2);
      #2 reset = 1'b0;
      idle(3);
      chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'd0);
      issue(1'b0, 16'hFFFF, 16'h0, 1'b0, acc);
      wait_rsp(at);
      chk("cleared_after_rst", 32'(bus.rsp_rdata), 32'h0);

      // 6: req_valid dropped while busy: nothing extra accepted
      idle(2);
      issue(1'b1, 16'h0042, 16'h5A5A, 1'b0, acc);
      wait_rsp(at);
      idle(2);
      rsp_cnt = 0;
      en_cnt = 0;
      issue(1'b0, 16'h0042, 16'h0, 1'b1, acc);
      @(negedge clk);
      bus.req_valid = 1'b0;
      idle(6);
      chk("drop_rsp_pulses", 32'(rsp_cnt), 32'd1);
      chk("drop_mem_cycles", 32'(en_cnt), 32'd2);
      chk("drop_rdata", 32'(bus.rsp_rdata), 32'h5A5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
